// File: rtl/sa_output_deskew_buffer_if.sv
// Bus between the systolic-array output skew stage and the CPU-side reader.
// The array side drives starts and data; the reader drives rd/pop/clear.
interface sa_output_deskew_buffer_if #(
  parameter int unsigned SA_SIZE    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned IDX_W = $clog2(SA_SIZE);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                          in_row_start;
  logic [SA_SIZE*DATA_WIDTH-1:0] in_data;
  logic                          in_ready;
  logic                          rd_en;
  logic [IDX_W-1:0]              rd_idx;
  logic [DATA_WIDTH-1:0]         rd_data;
  logic                          rd_valid;
  logic                          pop;
  logic                          clear;
  logic [CNT_W-1:0]              row_count;
  logic                          empty;
  logic                          full;
  logic                          overflow;

  modport master (
    output in_row_start, in_data, rd_en, rd_idx, pop, clear,
    input  in_ready, rd_data, rd_valid, row_count, empty, full, overflow
  );

  modport slave (
    input  in_row_start, in_data, rd_en, rd_idx, pop, clear,
    output in_ready, rd_data, rd_valid, row_count, empty, full, overflow
  );
endinterface

// File: rtl/sa_output_deskew_buffer.sv
// Realigns column-skewed result rows into whole rows, buffers up to DEPTH of
// them and serves the head row one element per read with one-cycle latency.
module sa_output_deskew_buffer #(
  parameter int unsigned SA_SIZE    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input logic                       clk,
  input logic                       resetn,
  sa_output_deskew_buffer_if.slave  io
);
  localparam int unsigned IDX_W  = $clog2(SA_SIZE);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam int unsigned ROW_W  = SA_SIZE * DATA_WIDTH;
  localparam int unsigned ROWX_W = (1 << IDX_W) * DATA_WIDTH;

  logic [ROW_W-1:0]      mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      row_count_q, row_count_d;
  logic [CNT_W-1:0]      inflight_q, inflight_d;
  logic [SA_SIZE-1:1]    tag_vld_q, tag_vld_d;
  logic [PTR_W-1:0]      tag_ptr_q [1:SA_SIZE-1];
  logic [PTR_W-1:0]      tag_ptr_d [1:SA_SIZE-1];
  logic                  in_ready_q, in_ready_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  overflow_q, overflow_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                  start_ok;
  logic                  commit;
  logic                  pop_ok;
  logic                  rd_ok;
  logic [ROWX_W-1:0]     head_ext;

  // Next-state logic; clear overrides everything but the held read data.
  always_comb begin
    start_ok = io.in_row_start & in_ready_q & ~io.clear;
    commit   = tag_vld_q[SA_SIZE-1];
    pop_ok   = io.pop & ~empty_q & ~io.clear;
    rd_ok    = io.rd_en & ~empty_q & ~io.clear;
    // Zero-padding makes out-of-range indices read back as 0.
    head_ext = ROWX_W'(mem_q[rd_ptr_q]);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_ok;
    tag_vld_d   = tag_vld_q;
    tag_ptr_d   = tag_ptr_q;

    tag_vld_d[1] = start_ok;
    tag_ptr_d[1] = wr_ptr_q;
    for (int k = 2; k < SA_SIZE; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_ptr_d[k] = tag_ptr_q[k-1];
    end

    if (start_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (io.in_row_start && !in_ready_q) overflow_d = 1'b1;
    if (rd_ok) rd_data_d = head_ext[32'(io.rd_idx) * DATA_WIDTH +: DATA_WIDTH];

    row_count_d = row_count_q + CNT_W'(commit) - CNT_W'(pop_ok);
    inflight_d  = inflight_q + CNT_W'(start_ok) - CNT_W'(commit);

    if (io.clear) begin
      tag_vld_d   = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      row_count_d = '0;
      inflight_d  = '0;
      overflow_d  = 1'b0;
      rd_valid_d  = 1'b0;
    end

    empty_d    = (row_count_d == '0);
    full_d     = (row_count_d == CNT_W'(DEPTH));
    in_ready_d = (SUM_W'(row_count_d) + SUM_W'(inflight_d)) < SUM_W'(DEPTH);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      row_count_q <= '0;
      inflight_q  <= '0;
      tag_vld_q   <= '0;
      in_ready_q  <= 1'b1;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      row_count_q <= row_count_d;
      inflight_q  <= inflight_d;
      tag_vld_q   <= tag_vld_d;
      in_ready_q  <= in_ready_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Row storage and slot tags: column 0 lands at start, column c via tag stage c.
  always_ff @(posedge clk) begin
    tag_ptr_q <= tag_ptr_d;
    if (start_ok) mem_q[wr_ptr_q][0 +: DATA_WIDTH] <= io.in_data[0 +: DATA_WIDTH];
    for (int c = 1; c < SA_SIZE; c++) begin
      if (tag_vld_q[c] && !io.clear)
        mem_q[tag_ptr_q[c]][c*DATA_WIDTH +: DATA_WIDTH] <= io.in_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.rd_data   = rd_data_q;
  assign io.rd_valid  = rd_valid_q;
  assign io.row_count = row_count_q;
  assign io.empty     = empty_q;
  assign io.full      = full_q;
  assign io.overflow  = overflow_q;
endmodule

// File: tb/tb_sa_output_deskew_buffer.sv
// Directed bench for sa_output_deskew_buffer (SA_SIZE=4, DEPTH=2, DATA_WIDTH=32).
// hist[c] holds the base value of the row whose column c is on in_data this cycle.
module tb_sa_output_deskew_buffer;
  localparam int unsigned SA = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned DP = 2;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;
  logic [31:0] hist [SA];

  sa_output_deskew_buffer_if #(.SA_SIZE(SA), .DATA_WIDTH(DW), .DEPTH(DP)) bus ();

  sa_output_deskew_buffer #(.SA_SIZE(SA), .DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk    (clk),
    .resetn (resetn),
    .io     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic upd();
    for (int c = 0; c < SA; c++) bus.in_data[c*DW +: DW] = hist[c] + 32'(c);
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int c = SA - 1; c > 0; c--) hist[c] = hist[c-1];
    hist[0]          = '0;
    bus.in_row_start = 1'b0;
    bus.rd_en        = 1'b0;
    bus.pop          = 1'b0;
    bus.clear        = 1'b0;
    upd();
  endtask

  task automatic start(input logic [31:0] base);
    hist[0]          = base;
    bus.in_row_start = 1'b1;
    upd();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    resetn = 1'b0;
    bus.in_row_start = 1'b0;
    bus.in_data      = '0;
    bus.rd_en        = 1'b0;
    bus.rd_idx       = '0;
    bus.pop          = 1'b0;
    bus.clear        = 1'b0;
    for (int c = 0; c < SA; c++) hist[c] = '0;
    ticks(2);

    chk("rst_rd_data",   bus.rd_data,   32'h0);
    chk("rst_rd_valid",  bus.rd_valid,  32'h0);
    chk("rst_row_count", bus.row_count, 32'h0);
    chk("rst_empty",     bus.empty,     32'h1);
    chk("rst_full",      bus.full,      32'h0);
    chk("rst_in_ready",  bus.in_ready,  32'h1);
    chk("rst_overflow",  bus.overflow,  32'h0);
    resetn = 1'b1;
    tick();

    // Single skewed row
    start(32'h1000);
    ticks(3);
    chk("single_precommit_count", bus.row_count, 32'h0);
    tick();
    chk("single_count", bus.row_count, 32'h1);
    chk("single_empty", bus.empty,     32'h0);
    chk("single_ready", bus.in_ready,  32'h1);
    for (int i = 0; i < SA; i++) begin
      bus.rd_en  = 1'b1;
      bus.rd_idx = 2'(i);
      tick();
      chk($sformatf("single_valid%0d", i), bus.rd_valid, 32'h1);
      chk($sformatf("single_data%0d", i),  bus.rd_data,  32'h1000 + 32'(i));
    end
    tick();
    chk("idle_valid", bus.rd_valid, 32'h0);
    chk("idle_hold",  bus.rd_data,  32'h1003);
    bus.pop = 1'b1;
    tick();
    chk("single_pop_count", bus.row_count, 32'h0);
    chk("single_pop_empty", bus.empty,     32'h1);

    // Back-to-back rows, third start dropped
    chk("b2b_ready_t0", bus.in_ready, 32'h1);
    start(32'h2000);
    tick();
    chk("b2b_ready_t1", bus.in_ready, 32'h1);
    start(32'h3000);
    tick();
    chk("b2b_ready_t2", bus.in_ready, 32'h0);
    start(32'h4000);
    tick();
    chk("b2b_overflow", bus.overflow,  32'h1);
    chk("b2b_count_t3", bus.row_count, 32'h0);
    tick();
    chk("b2b_count_t4", bus.row_count, 32'h1);
    chk("b2b_full_t4",  bus.full,      32'h0);
    tick();
    chk("b2b_full_t5",  bus.full,      32'h1);
    chk("b2b_count_t5", bus.row_count, 32'h2);
    chk("b2b_ready_t5", bus.in_ready,  32'h0);
    bus.rd_en = 1'b1; bus.rd_idx = 2'd2;
    tick();
    chk("b2b_row0_c2", bus.rd_data, 32'h2002);
    bus.rd_en = 1'b1; bus.rd_idx = 2'd3; bus.pop = 1'b1;
    tick();
    chk("b2b_rdpop_old_head", bus.rd_data,   32'h2003);
    chk("b2b_count_after_pop", bus.row_count, 32'h1);
    chk("b2b_ready_after_pop", bus.in_ready,  32'h1);
    bus.rd_en = 1'b1; bus.rd_idx = 2'd0;
    tick();
    chk("b2b_row1_c0", bus.rd_data, 32'h3000);
    bus.pop = 1'b1;
    tick();
    chk("b2b_final_count", bus.row_count, 32'h0);
    chk("b2b_final_empty", bus.empty,     32'h1);
    chk("b2b_sticky_ovf",  bus.overflow,  32'h1);

    // Clear mid-flight, also dominating a same-cycle start
    start(32'h5000);
    ticks(2);
    start(32'h5800);
    bus.clear = 1'b1;
    tick();
    chk("clr_count",    bus.row_count, 32'h0);
    chk("clr_ready",    bus.in_ready,  32'h1);
    chk("clr_overflow", bus.overflow,  32'h0);
    ticks(2);
    chk("clr_no_commit_t5", bus.row_count, 32'h0);
    ticks(2);
    chk("clr_no_commit_t7", bus.row_count, 32'h0);
    chk("clr_empty_t7",     bus.empty,     32'h1);

    // Commit and pop in the same cycle
    start(32'h6000);
    tick();
    start(32'h7000);
    ticks(3);
    chk("cp_count_before", bus.row_count, 32'h1);
    bus.pop = 1'b1;
    tick();
    chk("cp_count_same", bus.row_count, 32'h1);
    chk("cp_not_empty",  bus.empty,     32'h0);
    bus.rd_en = 1'b1; bus.rd_idx = 2'd1;
    tick();
    chk("cp_new_head", bus.rd_data, 32'h7001);
    bus.pop = 1'b1;
    tick();
    chk("cp_drained", bus.row_count, 32'h0);

    // Empty accesses
    bus.rd_en = 1'b1; bus.rd_idx = 2'd0; bus.pop = 1'b1;
    tick();
    chk("empty_rd_valid", bus.rd_valid,  32'h0);
    chk("empty_rd_hold",  bus.rd_data,   32'h7001);
    chk("empty_count",    bus.row_count, 32'h0);
    start(32'h8000);
    ticks(4);
    chk("empty_next_count", bus.row_count, 32'h1);
    bus.rd_en = 1'b1; bus.rd_idx = 2'd3;
    tick();
    chk("empty_next_data", bus.rd_data, 32'h8003);
    bus.pop = 1'b1;
    tick();

    // Wrap-around across pointer rollover
    for (int i = 0; i < 5; i++) begin
      start(32'hA0 + 32'(i));
      ticks(4);
      chk($sformatf("wrap_count%0d", i), bus.row_count, 32'h1);
      bus.rd_en = 1'b1; bus.rd_idx = 2'd0; bus.pop = 1'b1;
      tick();
      chk($sformatf("wrap_data%0d", i),  bus.rd_data,   32'hA0 + 32'(i));
      chk($sformatf("wrap_valid%0d", i), bus.rd_valid,  32'h1);
      chk($sformatf("wrap_popped%0d", i), bus.row_count, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
